// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller: FSM state encoding,
// command decoding and the seconds/minutes display limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_MAXED   = 2'd3
  } sw_state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_START,
    CMD_STOP,
    CMD_RESET
  } sw_cmd_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [7:0] MIN_MAX = 8'd99;

  // Only the highest-priority pulse is considered; if it is illegal in the
  // current state the lower-priority ones do not get a second chance.
  function automatic sw_cmd_e decode_cmd(input logic start_cmd,
                                         input logic stop_cmd,
                                         input logic reset_cmd);
    if (reset_cmd) return CMD_RESET;
    if (stop_cmd)  return CMD_STOP;
    if (start_cmd) return CMD_START;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_controller_tick_prescaler.sv
// One-second timebase: counts run cycles 0..TICKS_PER_SEC-1 and flags the
// terminal count; holds its value while run is low so pauses lose nothing.
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every variable gets its default before any branch, so no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == TERMINAL) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == TERMINAL);

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch run/pause/clear FSM owning the 0-59 seconds count and driving the
// external minutes counter. Optional lap capture under `STOPWATCH_LAP_EN.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
  output logic [5:0] lap_seconds,
  output logic [7:0] lap_minutes,
  output logic       lap_valid,
`endif
  input  logic       start,
  input  logic       stop,
  input  logic       reset,
  input  logic [7:0] minutes,
  output logic [5:0] seconds,
  output logic       min_enable,
  output logic       min_clear,
  output logic       running,
  output logic [1:0] state
);

  sw_state_e  state_q, state_d;
  logic [5:0] sec_q, sec_d;
  logic       min_en_q, min_en_d;
  logic       min_clr_q, min_clr_d;
  logic       running_q, running_d;
  logic       presc_clr;
  logic       tick;
  sw_cmd_e    cmd;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (state_q == ST_RUNNING),
    .clr  (presc_clr),
    .tick (tick)
  );

  assign cmd = decode_cmd(start, stop, reset);

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    min_en_d  = 1'b0;
    min_clr_d = 1'b0;
    presc_clr = 1'b0;

    if (cmd == CMD_RESET) begin
      state_d   = ST_IDLE;
      sec_d     = '0;
      min_clr_d = 1'b1;
      presc_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd == CMD_START) begin
            state_d   = ST_RUNNING;
            presc_clr = 1'b1;
          end
        end
        ST_RUNNING: begin
          // A tick is applied before a coincident stop takes effect.
          if (tick) begin
            if (sec_q < SEC_MAX) begin
              sec_d = sec_q + 6'd1;
            end else if (minutes < MIN_MAX) begin
              sec_d    = '0;
              min_en_d = 1'b1;
            end else begin
              state_d = ST_MAXED;
            end
          end
          if (cmd == CMD_STOP && state_d == ST_RUNNING) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (cmd == CMD_START) begin
            state_d = ST_RUNNING;
          end
        end
        ST_MAXED: begin
          state_d = ST_MAXED;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    running_d = (state_d == ST_RUNNING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sec_q     <= '0;
      min_en_q  <= 1'b0;
      min_clr_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      min_en_q  <= min_en_d;
      min_clr_q <= min_clr_d;
      running_q <= running_d;
    end
  end

  assign seconds    = sec_q;
  assign min_enable = min_en_q;
  assign min_clear  = min_clr_q;
  assign running    = running_q;
  assign state      = state_q;

`ifdef STOPWATCH_LAP_EN
  logic [5:0] lap_sec_q, lap_sec_d;
  logic [7:0] lap_min_q, lap_min_d;
  logic       lap_valid_q, lap_valid_d;

  always_comb begin
    lap_sec_d   = lap_sec_q;
    lap_min_d   = lap_min_q;
    lap_valid_d = lap_valid_q;
    if (cmd == CMD_RESET) begin
      lap_sec_d   = '0;
      lap_min_d   = '0;
      lap_valid_d = 1'b0;
    end else if (lap && state_q == ST_RUNNING) begin
      lap_sec_d   = sec_q;
      lap_min_d   = minutes;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_sec_q   <= '0;
      lap_min_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_sec_q   <= lap_sec_d;
      lap_min_q   <= lap_min_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_seconds = lap_sec_q;
  assign lap_minutes = lap_min_q;
  assign lap_valid   = lap_valid_q;
`endif

endmodule
